// File: rtl/mdu_if.sv
// Handshake and operand bus between the EX stage and the mul/div sequencer.
interface mdu_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, a, b, flush, input stall, busy, done, result);
    modport slave  (input start, op, a, b, flush, output stall, busy, done, result);
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply / restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up in a final cycle.
module mdu_seq #(parameter int XLEN = 32) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic              neg, neg_r;
    logic [XLEN-1:0]   result;

    logic              accept, a_sgn, b_sgn, a_neg, b_neg, ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_val;

    assign accept = (state == IDLE) & bus.start & ~bus.flush;
    assign a_sgn  = (bus.op == 3'd1) | (bus.op == 3'd2) | (bus.op == 3'd4) | (bus.op == 3'd6);
    assign b_sgn  = (bus.op == 3'd1) | (bus.op == 3'd4) | (bus.op == 3'd6);
    assign a_neg  = a_sgn & bus.a[XLEN-1];
    assign b_neg  = b_sgn & bus.b[XLEN-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;

    // Divide-by-zero and signed overflow finish without iterating.
    assign ovf         = ~bus.op[0] & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b);
    assign special     = bus.op[2] & ((bus.b == '0) | ovf);
    assign special_val = (bus.b == '0) ? (bus.op[1] ? bus.a : '1)
                                       : (bus.op[1] ? '0 : bus.a);

    // prod holds {hi, lo}: multiply = {partial sum, multiplier}; divide = {remainder, quotient}.
    logic [XLEN:0]     sum, rsh, diff;
    logic [2*XLEN-1:0] step;
    always_comb begin
        sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        rsh  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
        diff = rsh - {1'b0, mcand};
        if (!op_r[2])
            step = {sum, prod[XLEN-1:1]};
        else if (!diff[XLEN])
            step = {diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
        else
            step = {rsh[XLEN-1:0], prod[XLEN-2:0], 1'b0};
    end

    logic [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0]   quo, rem, fix_val;
    always_comb begin
        mul_p = neg ? -prod : prod;
        quo   = prod[XLEN-1:0];
        rem   = prod[2*XLEN-1:XLEN];
        case (op_r)
            3'd0:    fix_val = mul_p[XLEN-1:0];
            3'd4:    fix_val = neg ? -quo : quo;
            3'd5:    fix_val = quo;
            3'd6:    fix_val = neg_r ? -rem : rem;
            3'd7:    fix_val = rem;
            default: fix_val = mul_p[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (bus.flush) state_nxt = IDLE;
                     else if (cnt == CW'(XLEN-1)) state_nxt = FIX;
            FIX:     state_nxt = bus.flush ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_r   <= '0;
            mcand  <= '0;
            prod   <= '0;
            neg    <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_r  <= bus.op;
                    neg   <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    cnt   <= '0;
                    if (special) result <= special_val;
                    if (bus.op[2]) begin
                        prod  <= {{XLEN{1'b0}}, a_mag};
                        mcand <= b_mag;
                    end else begin
                        prod  <= {{XLEN{1'b0}}, b_mag};
                        mcand <= a_mag;
                    end
                end
                CALC: if (!bus.flush) begin
                    prod <= step;
                    cnt  <= cnt + CW'(1);
                end
                FIX: if (!bus.flush) result <= fix_val;
                default: ;
            endcase
        end
    end

    assign bus.stall  = accept | (state == CALC) | (state == FIX);
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: hand-computed RV32M results, latency, stall, flush and reset.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mdu_if #(.XLEN(32)) bus ();
    mdu_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Drive an op at a negedge, return at the negedge where done is seen.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat, output int stl);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        lat = 0; stl = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.stall) stl++;
        end while (!bus.done && lat < 100);
        res = bus.result;
        if (lat >= 100) begin
            failures++;
            $display("FAIL timeout op=%0d got no done", o);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        checks += 4;
        if (bus.busy   !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        if (bus.done   !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        if (bus.stall  !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
        if (bus.result !== 32'h0) begin failures++; $display("FAIL rst_result got=%h exp=0", bus.result); end
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, stl;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'hFFFFFFFD;
        #1 chk("mul_stall_start", {31'b0, bus.stall}, 32'd1);
        do_op(3'd0, 32'd7, 32'hFFFFFFFD, r, lat, stl);
        chk("mul_result", r, 32'hFFFFFFEB);
        chk("mul_latency", lat, 32'd34);
        chk("mul_stall_cycles", stl, 32'd33);
        @(negedge clk);
        chk("mul_done_one_cycle", {31'b0, bus.done}, 32'd0);
        chk("mul_idle_after", {31'b0, bus.busy}, 32'd0);
        do_op(3'd1, 32'h80000000, 32'h80000000, r, lat, stl);
        chk("mulh_min", r, 32'h40000000);
        @(negedge clk);
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, stl);
        chk("mulhu_max", r, 32'hFFFFFFFE);
        @(negedge clk);
        do_op(3'd2, 32'hFFFFFFFF, 32'd2, r, lat, stl);
        chk("mulhsu_neg", r, 32'hFFFFFFFF);
    endtask

    task automatic test_special();
        logic [31:0] r; int lat, stl;
        @(negedge clk);
        do_op(3'd5, 32'd5, 32'd0, r, lat, stl);
        chk("divu_by0", r, 32'hFFFFFFFF);
        chk("divu_by0_latency", lat, 32'd1);
        @(negedge clk);
        do_op(3'd7, 32'd9, 32'd0, r, lat, stl);
        chk("remu_by0", r, 32'd9);
        @(negedge clk);
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, r, lat, stl);
        chk("div_ovf", r, 32'h80000000);
        chk("div_ovf_latency", lat, 32'd1);
        @(negedge clk);
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, r, lat, stl);
        chk("rem_ovf", r, 32'h0);
    endtask

    task automatic test_div();
        logic [31:0] r; int lat, stl;
        @(negedge clk);
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, r, lat, stl);
        chk("div_neg", r, 32'hFFFFFFFD);
        chk("div_latency", lat, 32'd34);
        @(negedge clk);
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, r, lat, stl);
        chk("rem_neg", r, 32'hFFFFFFFF);
        @(negedge clk);
        do_op(3'd5, 32'd100, 32'd7, r, lat, stl);
        chk("divu_100_7", r, 32'd14);
        @(negedge clk);
        do_op(3'd7, 32'd7, 32'd2, r, lat, stl);
        chk("remu_7_2", r, 32'd1);
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat, stl, seen;
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.a = 32'd50; bus.b = 32'd3;
        #1 chk("flush_start_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start_not_accepted", {31'b0, bus.busy}, 32'd0);
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_to_idle", {31'b0, bus.busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen++;
            @(negedge clk);
        end
        chk("flush_no_done", seen, 32'd0);
        chk("flush_result_held", bus.result, 32'd1);
        do_op(3'd4, 32'd100, 32'hFFFFFFF9, r, lat, stl);
        chk("after_flush_div", r, 32'hFFFFFFF2);
        chk("after_flush_latency", lat, 32'd34);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat, stl, dones;
        @(negedge clk);
        do_op(3'd0, 32'd3, 32'd5, r, lat, stl);
        chk("b2b_first", r, 32'd15);
        // start raised in the DONE cycle must be ignored
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_done_ignored", {31'b0, bus.busy}, 32'd0);
        // start pulsed mid-op must not re-latch
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hFFFFFFF9; bus.b = 32'd2;
        dones = 0; lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            bus.start = (i == 5);
            if (i == 5) begin bus.op = 3'd5; bus.a = 32'd9; bus.b = 32'd4; end
            if (bus.done) begin dones++; lat = i; r = bus.result; end
        end
        bus.start = 1'b0;
        chk("busy_start_one_done", dones, 32'd1);
        chk("busy_start_result", r, 32'hFFFFFFFD);
        chk("busy_start_latency", lat, 32'd34);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd123; bus.b = 32'd456;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mid_stall", {31'b0, bus.stall}, 32'd0);
        chk("rst_mid_done", {31'b0, bus.done}, 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        #1 test_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_mul();
        test_special();
        test_div();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
